// File: rtl/sync_ram_bank_register_sync.sv
`default_nettype none
// ============================================================================
// Module   : register_sync
// Purpose  : Generic one-cycle pipeline register with synchronous
//            reset-to-zero. Used as the optional output stage of
//            sync_ram_bank and for the IBUF request/address forwarding chain.
// Ports    : clk   - rising-edge clock
//            reset - synchronous, active-high; clears out to 0
//            in    - WIDTH-bit data in
//            out   - WIDTH-bit data out, in delayed by one cycle
// Revision : 1.0 - initial release
// ============================================================================
module register_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_ram_bank.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_bank
// Purpose  : One lane of the input buffer. Single write port / single read
//            port synchronous RAM, read-first on address collision, with an
//            optional output register (read latency 1 or 2 cycles).
// Ports    : clk          - rising-edge clock
//            reset        - synchronous, active-high; clears read registers
//                           only, memory contents are kept
//            s_write_req  - write enable
//            s_write_addr - write word address
//            s_write_data - write word
//            s_read_req   - read enable
//            s_read_addr  - read word address
//            s_read_data  - read word (0 after reset until a read completes)
// Revision : 1.0 - initial release
// ============================================================================
module sync_ram_bank #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_REG = 1,
  parameter     TYPE       = "block"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req,
  input  logic [ADDR_WIDTH-1:0] s_write_addr,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic                  s_read_req,
  input  logic [ADDR_WIDTH-1:0] s_read_addr,
  output logic [DATA_WIDTH-1:0] s_read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // First read stage; holds its value while no read is requested.
  logic [DATA_WIDTH-1:0] rd_q;

  // The array and rd_q are duplicated per implementation hint only so the
  // ram_style attribute can be a literal. Both branches behave identically:
  // non-blocking read of the old word gives read-first on collision, and
  // requests during reset are dropped.
  generate
    if (TYPE == "distributed") begin : g_distributed
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset && s_write_req) begin
          mem[s_write_addr] <= s_write_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q <= '0;
        end else if (s_read_req) begin
          rd_q <= mem[s_read_addr];
        end
      end
    end else begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset && s_write_req) begin
          mem[s_write_addr] <= s_write_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q <= '0;
        end else if (s_read_req) begin
          rd_q <= mem[s_read_addr];
        end
      end
    end
  endgenerate

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_q;

      // Free-running: simply re-registers rd_q every cycle.
      register_sync #(
        .WIDTH (DATA_WIDTH)
      ) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .in    (rd_q),
        .out   (out_q)
      );

      assign s_read_data = out_q;
    end else begin : g_no_out_reg
      assign s_read_data = rd_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_ram_bank
// Purpose  : Self-checking bench for sync_ram_bank (both output-register
//            settings) and register_sync, against a word-array reference
//            model of the RAM and its read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_ram_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [31:0] rd_data_r1;
  logic [31:0] rd_data_r0;
  logic        rs_rst = 1'b0;
  logic [9:0]  rs_in = '0;
  logic [9:0]  rs_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents plus "has been written" flags, and the value
  // currently expected after one and two cycles of read latency.
  logic [31:0] mdl_mem   [1024];
  bit          mdl_known [1024];
  logic [31:0] exp_lat1 = '0;
  bit          exp_lat1_known = 1'b1;
  logic [31:0] exp_lat2 = '0;
  bit          exp_lat2_known = 1'b1;
  logic [9:0]  rs_exp = '0;

  always #5 clk = ~clk;

  sync_ram_bank #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .OUTPUT_REG (1),
    .TYPE       ("block")
  ) u_dut_r1 (
    .clk          (clk),
    .reset        (rst),
    .s_write_req  (wr_req),
    .s_write_addr (wr_addr),
    .s_write_data (wr_data),
    .s_read_req   (rd_req),
    .s_read_addr  (rd_addr),
    .s_read_data  (rd_data_r1)
  );

  sync_ram_bank #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .OUTPUT_REG (0),
    .TYPE       ("distributed")
  ) u_dut_r0 (
    .clk          (clk),
    .reset        (rst),
    .s_write_req  (wr_req),
    .s_write_addr (wr_addr),
    .s_write_data (wr_data),
    .s_read_req   (rd_req),
    .s_read_addr  (rd_addr),
    .s_read_data  (rd_data_r0)
  );

  register_sync #(
    .WIDTH (10)
  ) u_reg (
    .clk   (clk),
    .reset (rs_rst),
    .in    (rs_in),
    .out   (rs_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, compare at the next falling edge.
  task automatic cycle(input logic r, input logic we, input logic [9:0] wa,
                       input logic [31:0] wd, input logic re, input logic [9:0] ra);
    rst = r; wr_req = we; wr_addr = wa; wr_data = wd; rd_req = re; rd_addr = ra;
    @(posedge clk);
    if (r) begin
      exp_lat1 = '0; exp_lat1_known = 1'b1;
      exp_lat2 = '0; exp_lat2_known = 1'b1;
    end else begin
      // Two-cycle output shows what the one-cycle output showed last cycle.
      exp_lat2 = exp_lat1; exp_lat2_known = exp_lat1_known;
      // Read-first: fetch the old word before applying this cycle's write.
      if (re) begin
        exp_lat1 = mdl_mem[ra]; exp_lat1_known = mdl_known[ra];
      end
      if (we) begin
        mdl_mem[wa] = wd; mdl_known[wa] = 1'b1;
      end
    end
    rs_exp = rs_rst ? 10'd0 : rs_in;
    @(negedge clk);
    if (exp_lat1_known) check("read_lat1", rd_data_r0, exp_lat1);
    if (exp_lat2_known) check("read_lat2", rd_data_r1, exp_lat2);
    check("register_sync", {22'd0, rs_out}, {22'd0, rs_exp});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      mdl_mem[a] = '0; mdl_known[a] = 1'b0;
    end
    @(negedge clk);

    // Reset for two cycles; the requests issued meanwhile must be ignored.
    cycle(1'b1, 1'b1, 10'h005, 32'hBAD0BAD0, 1'b1, 10'h005);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("reset_r1", rd_data_r1, 32'd0);
    check("reset_r0", rd_data_r0, 32'd0);
    idle(2);

    // Basic write then read; value must hold afterwards.
    cycle(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, '0);
    idle(1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h005);
    check("basic_lat1", rd_data_r0, 32'hDEADBEEF);
    check("basic_lat2_not_yet", rd_data_r1, 32'd0);
    idle(1);
    check("basic_lat2", rd_data_r1, 32'hDEADBEEF);
    idle(3);
    check("basic_hold", rd_data_r1, 32'hDEADBEEF);

    // Read-first collision at the top address.
    cycle(1'b0, 1'b1, 10'h3FF, 32'h11111111, 1'b0, '0);
    cycle(1'b0, 1'b1, 10'h3FF, 32'h22222222, 1'b1, 10'h3FF);
    check("collision_old", rd_data_r0, 32'h11111111);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h3FF);
    check("collision_new", rd_data_r0, 32'h22222222);
    idle(2);

    // Streaming writes and back-to-back reads.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 10'(i), 32'(i * 3), 1'b0, '0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'(i));
    idle(2);
    check("stream_last", rd_data_r1, 32'd45);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("midreset_r1", rd_data_r1, 32'd0);
    check("midreset_r0", rd_data_r0, 32'd0);
    idle(1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 10'h005);
    check("after_reset_mem5", rd_data_r0, 32'd15);
    idle(2);

    // register_sync directed cases.
    rs_in = 10'h2AB; rs_rst = 1'b0;
    idle(1);
    check("regsync_2ab", {22'd0, rs_out}, 32'h2AB);
    rs_in = 10'h3FF; rs_rst = 1'b1;
    idle(1);
    check("regsync_reset", {22'd0, rs_out}, 32'd0);
    rs_rst = 1'b0;

    // Randomized traffic, mostly on a small address window for collisions.
    for (int n = 0; n < 400; n++) begin
      logic [9:0] wa, ra;
      wa = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
      ra = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
      rs_in  = 10'($urandom);
      rs_rst = ($urandom_range(0, 15) == 0);
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), wa, $urandom,
            1'($urandom), ra);
    end
    rs_rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
